frame_ram_arbiter: RTL
======================

FRAME_RAM_ARBITER -- requirements
Module: frame_ram_arbiter

Interface
REQ-001 Parameter ADDR_W, 17, frame buffer address width.
REQ-002 Parameter DATA_W, 24, pixel width {B,G,R}.
REQ-003 Parameter FIFO_DEPTH, 4, write buffer entries, power of two, minimum 2.
REQ-004 Parameter ADDR_MAX, 129599, highest legal pixel address.
REQ-005 One clock; reset is asynchronous and active-low.
REQ-006 clk  in  1  rising-edge clock.
REQ-007 reset  in  1  asynchronous active-low reset.
REQ-008 wr_valid  in  1  one-cycle write strobe from serial assembler.
REQ-009 wr_addr  in  ADDR_W  write pixel address.
REQ-010 wr_data  in  DATA_W  write pixel data.
REQ-011 rd_req  in  1  VGA read request, level per pixel.
REQ-012 rd_addr  in  ADDR_W  VGA read address.
REQ-013 rd_data  out  DATA_W  read pixel, registered.
REQ-014 rd_valid  out  1  rd_data qualifier.
REQ-015 ram_addr  out  ADDR_W  RAM address, registered.
REQ-016 ram_wdata  out  DATA_W  RAM write data, registered.
REQ-017 ram_we  out  1  RAM write enable, registered.
REQ-018 ram_rdata  in  DATA_W  RAM read data, one-cycle synchronous latency.
REQ-019 wr_full  out  1  write buffer full.
REQ-020 drop_cnt  out  16  dropped-write count (macro only).

Function
REQ-021 FSM states IDLE, READ, WRITE; state registered, next-state combinational.
REQ-022 rd_req=1 in cycle n SHALL enter READ: cycle n+1 ram_addr=rd_addr, ram_we=0; cycle n+2 rd_data=ram_rdata, rd_valid=1.
REQ-023 Read latency SHALL be exactly 2 cycles; back-to-back rd_req SHALL yield one read per cycle.
REQ-024 Reads SHALL have absolute priority; a pending write SHALL stall while rd_req=1.
REQ-025 rd_req=0 and buffer non-empty SHALL enter WRITE: pop head, next cycle ram_addr/ram_wdata=head, ram_we=1 for exactly one cycle.
REQ-026 rd_req=0 and buffer empty SHALL enter IDLE with ram_we=0, ram_addr held.
REQ-027 wr_valid with wr_addr<=ADDR_MAX and buffer not full SHALL push in the same cycle.
REQ-028 Push and pop in the same cycle SHALL both occur, occupancy unchanged, including when full.
REQ-029 wr_valid when full and no pop SHALL drop the write; buffer contents unchanged.
REQ-030 wr_valid with wr_addr>ADDR_MAX SHALL be discarded, never pushed.
REQ-031 Writes SHALL reach RAM in arrival order.
REQ-032 FIFO pointers SHALL wrap modulo FIFO_DEPTH; wr_full asserted when occupancy==FIFO_DEPTH.
REQ-033 rd_valid SHALL be 0 in every cycle not following a READ-issue cycle.

Reset
REQ-034 reset low SHALL immediately force state=IDLE, ram_we=0, ram_addr=0, ram_wdata=0, rd_data=0, rd_valid=0, wr_full=0, FIFO empty, drop_cnt=0.
REQ-035 Reset mid-write SHALL deassert ram_we asynchronously; buffered writes are lost.
REQ-036 First transaction after reset release SHALL start no earlier than the first clk edge with reset high.

Configuration
REQ-037 Macro FRAME_ARB_DROP_CNT_EN defined: drop_cnt increments by 1 per dropped or discarded write (REQ-029, REQ-030), saturating at 65535.
REQ-038 Macro FRAME_ARB_DROP_CNT_EN undefined: drop_cnt port absent, no counter logic; drops silent.

Structure
REQ-039 Package frame_arb_pkg SHALL hold the state enum, ADDR_MAX default, DATA_W default, pixel_t typedef.
REQ-040 Sub-module arb_wr_fifo SHALL implement the write buffer (push, pop, full, empty, head data).

Verification
REQ-041 Reset release, rd_req=1 at addr 5, ram_rdata=0xA1B2C3 -> ram_addr=5 at n+1, rd_data=0xA1B2C3, rd_valid=1 at n+2.
REQ-042 Write pulse addr 10 data 0x00FF00, rd_req=0 -> ram_we=1 with ram_addr=10, ram_wdata=0x00FF00 exactly one cycle.
REQ-043 rd_req held 8 cycles, 3 writes arriving meanwhile -> no ram_we during reads, then 3 writes in order on consecutive cycles.
REQ-044 rd_req held, 6 writes with FIFO_DEPTH=4 -> wr_full=1, writes 5 and 6 dropped, drop_cnt=2 (macro on).
REQ-045 Write addr 129600 -> no push, ram_we never asserts, drop_cnt=1 (macro on).
REQ-046 reset low during WRITE cycle -> ram_we=0 before next clk edge, FIFO empty after release.

Source files
------------

// File: rtl/frame_arb_pkg.sv
// Shared types and defaults for the frame RAM arbiter: FSM state encoding,
// default geometry of the 320x405-style frame buffer, pixel type and a
// saturating counter helper.
package frame_arb_pkg;

    localparam int          ADDR_W_DEF     = 17;
    localparam int          DATA_W_DEF     = 24;
    localparam int          FIFO_DEPTH_DEF = 4;
    localparam int unsigned ADDR_MAX_DEF   = 129599;
    localparam int          DROP_CNT_W     = 16;

    // Pixel packed as {B,G,R}
    typedef logic [DATA_W_DEF-1:0] pixel_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_READ  = 2'b01,
        ST_WRITE = 2'b10
    } arb_state_t;

    // Increment that sticks at all-ones instead of wrapping
    function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
        logic [DROP_CNT_W-1:0] r;
        if (v == {DROP_CNT_W{1'b1}}) begin
            r = v;
        end else begin
            r = v + {{(DROP_CNT_W-1){1'b0}}, 1'b1};
        end
        return r;
    endfunction

endpackage

// File: rtl/arb_wr_fifo.sv
// Write buffer for the frame RAM arbiter: small circular FIFO of
// {address, pixel} entries with registered full/empty flags.
// Pointers wrap naturally because DEPTH is a power of two.
module arb_wr_fifo #(
    parameter int ADDR_W = 17,
    parameter int DATA_W = 24,
    parameter int DEPTH  = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              push_i,
    input  logic [ADDR_W-1:0] push_addr_i,
    input  logic [DATA_W-1:0] push_data_i,
    input  logic              pop_i,
    output logic [ADDR_W-1:0] head_addr_o,
    output logic [DATA_W-1:0] head_data_o,
    output logic              full_o,
    output logic              empty_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] addr_mem_q [DEPTH];
    logic [DATA_W-1:0] data_mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              full_q, empty_q;
    logic              push_s, pop_s;

    // A push while full is only accepted when a pop frees a slot in the same cycle
    assign push_s = push_i & (~full_q | pop_i);
    assign pop_s  = pop_i & ~empty_q;

    // Pointer and occupancy next-state
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + {{(PTR_W-1){1'b0}}, 1'b1};
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + {{(PTR_W-1){1'b0}}, 1'b1};
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
            2'b01:   count_d = count_q - {{(CNT_W-1){1'b0}}, 1'b1};
            default: count_d = count_q;
        endcase
    end

    // Pointer, occupancy and flag registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= (count_d == CNT_W'(DEPTH));
            empty_q  <= (count_d == '0);
        end
    end

    // Entry storage; cleared on reset so no stale pixel can ever leave the buffer
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                addr_mem_q[i] <= '0;
                data_mem_q[i] <= '0;
            end
        end else if (push_s) begin
            addr_mem_q[wr_ptr_q] <= push_addr_i;
            data_mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign head_addr_o = addr_mem_q[rd_ptr_q];
    assign head_data_o = data_mem_q[rd_ptr_q];
    assign full_o      = full_q;
    assign empty_o     = empty_q;

endmodule

// File: rtl/frame_ram_arbiter.sv
// Frame RAM arbiter: shares one single-port frame RAM between the VGA read
// path (absolute priority, 2-cycle registered latency) and a buffered pixel
// write path. Writes are queued in arb_wr_fifo and drained when no read is
// requested. Optional macro FRAME_ARB_DROP_CNT_EN adds a saturating count of
// dropped (buffer full) and discarded (address out of range) writes.
module frame_ram_arbiter
    import frame_arb_pkg::*;
#(
    parameter int          ADDR_W     = ADDR_W_DEF,
    parameter int          DATA_W     = DATA_W_DEF,
    parameter int          FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int unsigned ADDR_MAX   = ADDR_MAX_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_valid,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic                  rd_req,
    input  logic [ADDR_W-1:0]     rd_addr,
    output logic [DATA_W-1:0]     rd_data,
    output logic                  rd_valid,
    output logic [ADDR_W-1:0]     ram_addr,
    output logic [DATA_W-1:0]     ram_wdata,
    output logic                  ram_we,
    input  logic [DATA_W-1:0]     ram_rdata,
`ifdef FRAME_ARB_DROP_CNT_EN
    output logic [DROP_CNT_W-1:0] drop_cnt,
`endif
    output logic                  wr_full
);

    // One extra bit so any ADDR_MAX up to the full address range compares correctly
    localparam logic [ADDR_W:0] ADDR_LIMIT = (ADDR_W+1)'(ADDR_MAX);

    arb_state_t        state_q, state_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
    logic              ram_we_q, ram_we_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;

    logic              addr_ok_s;
    logic              push_s, pop_s;
    logic              fifo_full_s, fifo_empty_s;
    logic [ADDR_W-1:0] head_addr_s;
    logic [DATA_W-1:0] head_data_s;

    assign addr_ok_s = ({1'b0, wr_addr} <= ADDR_LIMIT);
    // Push also when full if the arbiter drains the head in the same cycle
    assign push_s    = wr_valid & addr_ok_s & (~fifo_full_s | pop_s);

    arb_wr_fifo #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_wr_fifo (
        .clk_i       (clk),
        .rst_ni      (reset),
        .push_i      (push_s),
        .push_addr_i (wr_addr),
        .push_data_i (wr_data),
        .pop_i       (pop_s),
        .head_addr_o (head_addr_s),
        .head_data_o (head_data_s),
        .full_o      (fifo_full_s),
        .empty_o     (fifo_empty_s)
    );

    // Arbitration: read wins, otherwise drain one buffered write, otherwise idle
    always_comb begin
        state_d     = state_q;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        ram_we_d    = 1'b0;
        pop_s       = 1'b0;
        if (rd_req) begin
            state_d    = ST_READ;
            ram_addr_d = rd_addr;
        end else if (!fifo_empty_s) begin
            state_d     = ST_WRITE;
            pop_s       = 1'b1;
            ram_addr_d  = head_addr_s;
            ram_wdata_d = head_data_s;
            ram_we_d    = 1'b1;
        end else begin
            state_d = ST_IDLE;
        end
    end

    // Read return: capture RAM data in the cycle after a read was issued
    always_comb begin
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        case (state_q)
            ST_READ: begin
                rd_data_d  = ram_rdata;
                rd_valid_d = 1'b1;
            end
            ST_IDLE, ST_WRITE: begin
                rd_data_d  = rd_data_q;
                rd_valid_d = 1'b0;
            end
            default: begin
                rd_data_d  = rd_data_q;
                rd_valid_d = 1'b0;
            end
        endcase
    end

    // State and registered RAM/read-port outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            ram_we_q    <= 1'b0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            ram_we_q    <= ram_we_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
        end
    end

`ifdef FRAME_ARB_DROP_CNT_EN
    logic                  drop_s;
    logic [DROP_CNT_W-1:0] drop_cnt_q;

    // Any write strobe that does not land in the buffer is a drop
    assign drop_s = wr_valid & ~push_s;

    // Saturating drop counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            drop_cnt_q <= '0;
        end else if (drop_s) begin
            drop_cnt_q <= sat_inc(drop_cnt_q);
        end else begin
            drop_cnt_q <= drop_cnt_q;
        end
    end

    assign drop_cnt = drop_cnt_q;
`endif

    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign ram_we    = ram_we_q;
    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign wr_full   = fifo_full_s;

endmodule
